// File: rtl/reg_stage_skid_if.sv
// Handshake bundle for reg_stage_skid: upstream write side, downstream read side, flush.
// master drives inp/in_valid/out_ready/flush; slave (the stage) drives in_ready/out/out_valid.
interface reg_stage_skid_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] inp;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             flush;

  modport master (
    output inp, in_valid, out_ready, flush,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  inp, in_valid, out_ready, flush,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/reg_stage_skid.sv
// Elastic two-entry (main + skid) pipeline stage with registered in_ready.
// Ports: clk, rst_n (async active-low), bus (slave: inp/in_valid/in_ready, out/out_valid/out_ready, flush).
module reg_stage_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  reg_stage_skid_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_wr;
  logic             w_rd;

  assign w_wr = bus.in_valid & r_in_ready;
  assign w_rd = r_out_valid & bus.out_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_main;

  // in_ready/out_valid are kept as flops alongside the state so neither
  // output has a combinational path from the consumer side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (bus.flush) begin
      // main keeps its value so out holds while out_valid is low
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_wr) begin
            r_main      <= bus.inp;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_wr && w_rd) begin
            r_main <= bus.inp;
          end else if (w_wr) begin
            r_skid     <= bus.inp;
            r_in_ready <= 1'b0;
            r_state    <= S_FULL;
          end else if (w_rd) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_rd) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
